// File: rtl/capture_unit.sv
// ---------------------------------------------------------------------------
// capture_unit
//   Receive-side serial capture engine. Samples a serial bit stream on a
//   single-cycle strobe while the frame qualifier is high. It packs the bits
//   MSB-first into WORD_W-bit words and hands each finished word to a BRAM
//   write path over a valid/ready handshake. A capture stops after a
//   programmed number of words, or when the frame ends. A partially built
//   word is then flushed left-aligned.
//
// Ports
//   i_clk           system clock, rising edge
//   i_reset         synchronous active-high reset
//   i_enable        level; rising edge arms a capture, low aborts it
//   i_capture_num   words to capture, latched when a capture is armed
//   i_sample_strobe one-clk pulse per bit period
//   i_d_in          serial data bit
//   i_d_enable      frame-active qualifier
//   o_write_data    packed word, left-aligned
//   o_write_valid   o_write_data holds a word
//   i_write_ready   sink accepts the word this cycle
//   o_last_bits     valid bits in o_write_data (WORD_W for a full word)
//   o_word_count    words transferred since arm (saturating)
//   o_complete      capture finished; held until i_enable is low
//   o_overflow      sticky; a completed word was dropped
// ---------------------------------------------------------------------------
module capture_unit #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic [CNT_W-1:0]  i_capture_num,
   input  logic              i_sample_strobe,
   input  logic              i_d_in,
   input  logic              i_d_enable,
   output logic [WORD_W-1:0] o_write_data,
   output logic              o_write_valid,
   input  logic              i_write_ready,
   output logic [5:0]        o_last_bits,
   output logic [CNT_W-1:0]  o_word_count,
   output logic              o_complete,
   output logic              o_overflow
);

   localparam int BIT_W = $clog2(WORD_W);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_FLUSH   = 3'd3,
      ST_DRAIN   = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic                r_enable_q;
   logic [CNT_W-1:0]    r_cap_num;
   logic [WORD_W-1:0]   r_shift;
   logic [BIT_W-1:0]    r_bit_cnt;
   logic [WORD_W-1:0]   r_hold_data;
   logic                r_hold_valid;
   logic [5:0]          r_last_bits;
   logic [CNT_W-1:0]    r_word_count;
   logic                r_complete;
   logic                r_overflow;

   logic                w_arm;
   logic                w_abort;
   logic                w_transfer;
   logic [CNT_W-1:0]    w_wc_inc;
   logic                w_limit_hit;
   logic [BIT_W:0]      w_flush_sh;
   logic [WORD_W-1:0]   w_flush_data;
   logic                w_sample;
   logic                w_word_done;
   logic                w_load_full;
   logic                w_load_flush;
   logic                w_drop;
   logic                w_complete_nxt;

   // Arming only happens from IDLE; any active state drops to IDLE when enable is low.
   assign w_arm        = (r_state == ST_IDLE) & i_enable & ~r_enable_q;
   assign w_abort      = (r_state != ST_IDLE) & ~i_enable;
   assign w_transfer   = r_hold_valid & i_write_ready;
   // Saturating increment so the counter never wraps back to zero.
   assign w_wc_inc     = (r_word_count == {CNT_W{1'b1}}) ? r_word_count
                                                         : r_word_count + {{(CNT_W-1){1'b0}}, 1'b1};
   // The transfer that brings the count up to the programmed limit ends the capture.
   assign w_limit_hit  = w_transfer & (w_wc_inc >= r_cap_num);
   // The partial word sits in the low bits of the shift register; move it to the top.
   assign w_flush_sh   = (BIT_W+1)'(WORD_W) - {1'b0, r_bit_cnt};
   assign w_flush_data = r_shift << w_flush_sh;

   assign o_write_data  = r_hold_data;
   assign o_write_valid = r_hold_valid;
   assign o_last_bits   = r_last_bits;
   assign o_word_count  = r_word_count;
   assign o_complete    = r_complete;
   assign o_overflow    = r_overflow;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next_state = r_state;
      if (w_abort) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_arm) begin
                  w_next_state = (i_capture_num == {CNT_W{1'b0}}) ? ST_DONE : ST_ARMED;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end
            ST_ARMED: begin
               if (i_d_enable) begin
                  w_next_state = ST_CAPTURE;
               end else begin
                  w_next_state = ST_ARMED;
               end
            end
            ST_CAPTURE: begin
               if (w_limit_hit) begin
                  w_next_state = ST_DONE;
               end else if (!i_d_enable) begin
                  w_next_state = (r_bit_cnt != {BIT_W{1'b0}}) ? ST_FLUSH : ST_DRAIN;
               end else begin
                  w_next_state = ST_CAPTURE;
               end
            end
            ST_FLUSH: begin
               if (w_limit_hit) begin
                  w_next_state = ST_DONE;
               end else if (!r_hold_valid || w_transfer) begin
                  w_next_state = ST_DRAIN;
               end else begin
                  w_next_state = ST_FLUSH;
               end
            end
            ST_DRAIN: begin
               if (!r_hold_valid) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = ST_DRAIN;
               end
            end
            ST_DONE: begin
               w_next_state = ST_DONE;
            end
            default: begin
               w_next_state = ST_IDLE;
            end
         endcase
      end
   end

   // Datapath controls derived from the current state.
   always_comb begin
      w_sample       = 1'b0;
      w_word_done    = 1'b0;
      w_load_full    = 1'b0;
      w_load_flush   = 1'b0;
      w_drop         = 1'b0;
      w_complete_nxt = 1'b0;
      case (r_state)
         ST_CAPTURE: begin
            w_sample    = i_enable & i_sample_strobe & i_d_enable;
            w_word_done = w_sample & (r_bit_cnt == BIT_W'(WORD_W - 1));
            if (w_word_done) begin
               // Once the limit is reached, the rest of the stream is ignored.
               if (w_limit_hit) begin
                  w_load_full = 1'b0;
               end else if (r_hold_valid && !w_transfer) begin
                  w_drop = 1'b1;
               end else begin
                  w_load_full = 1'b1;
               end
            end else begin
               w_load_full = 1'b0;
            end
         end
         ST_FLUSH: begin
            if (i_enable && !w_limit_hit && (!r_hold_valid || w_transfer)) begin
               w_load_flush = 1'b1;
            end else begin
               w_load_flush = 1'b0;
            end
         end
         ST_DONE: begin
            w_complete_nxt = i_enable;
         end
         default: begin
            w_sample = 1'b0;
         end
      endcase
   end

   // Enable history for rising-edge detection.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_enable_q <= 1'b0;
      end else begin
         r_enable_q <= i_enable;
      end
   end

   // Shift register and bit counter; the counter wraps to zero on the last bit of a word.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_shift   <= {WORD_W{1'b0}};
         r_bit_cnt <= {BIT_W{1'b0}};
      end else if (w_abort || w_arm || w_load_flush) begin
         r_shift   <= {WORD_W{1'b0}};
         r_bit_cnt <= {BIT_W{1'b0}};
      end else if (w_sample) begin
         r_shift   <= {r_shift[WORD_W-2:0], i_d_in};
         r_bit_cnt <= r_bit_cnt + {{(BIT_W-1){1'b0}}, 1'b1};
      end
   end

   // Holding register. A new word may replace one that transfers on the same edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hold_data  <= {WORD_W{1'b0}};
         r_hold_valid <= 1'b0;
         r_last_bits  <= 6'd0;
      end else if (w_abort) begin
         r_hold_valid <= 1'b0;
      end else if (w_load_full) begin
         r_hold_data  <= {r_shift[WORD_W-2:0], i_d_in};
         r_hold_valid <= 1'b1;
         r_last_bits  <= 6'(WORD_W);
      end else if (w_load_flush) begin
         r_hold_data  <= w_flush_data;
         r_hold_valid <= 1'b1;
         r_last_bits  <= 6'(r_bit_cnt);
      end else if (w_transfer) begin
         r_hold_valid <= 1'b0;
      end
   end

   // Word limit, transfer count and overflow flag. Abort leaves the count and flag visible.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cap_num    <= {CNT_W{1'b0}};
         r_word_count <= {CNT_W{1'b0}};
         r_overflow   <= 1'b0;
      end else if (w_arm) begin
         r_cap_num    <= i_capture_num;
         r_word_count <= {CNT_W{1'b0}};
         r_overflow   <= 1'b0;
      end else if (!w_abort) begin
         if (w_transfer) begin
            r_word_count <= w_wc_inc;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Completion flag, registered from the DONE state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_complete <= 1'b0;
      end else begin
         r_complete <= w_complete_nxt;
      end
   end

endmodule

// File: doc/capture_unit.md
Name: capture_unit

Overview:
- Receive-side counterpart of the playback path. Samples a serial bit stream (dIn qualified by dEnable) on a single-cycle sample strobe and packs the bits MSB-first into 32-bit words.
- Hands finished words to the BRAM write path over a valid/ready handshake, one word per transfer.
- Stops after a programmed number of words, or when the frame ends (dEnable falls), then raises complete.

Parameters:
WORD_W, 32, bits per packed word
CNT_W, 16, width of captureNum and wordCount

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  level; a rising edge arms a capture, a low level aborts it
captureNum  input  CNT_W  words to capture; latched on enable rising edge
sampleStrobe  input  1  one-clk pulse per bit period
dIn  input  1  serial data, sampled when sampleStrobe=1 and dEnable=1
dEnable  input  1  frame-active qualifier
writeData  output  WORD_W  packed word, left-aligned
writeValid  output  1  writeData holds a word
writeReady  input  1  sink accepts the word this cycle
lastBits  output  6  valid bits in writeData: 32 for a full word, 1-31 for a flushed partial word
wordCount  output  CNT_W  words transferred since arm
complete  output  1  capture finished; held until enable is low or reset
overflow  output  1  sticky; a completed word was dropped

Behaviour:
- Reset (synchronous, active-high): every output is 0, the state is IDLE, and the shift register, bit counter and holding register are cleared. Reset mid-capture has the same effect on the next edge; a partially built word is discarded.
- Latches and counters: a 32-bit shift register and a 5-bit bit counter, plus a one-word holding register that drives writeData, writeValid and lastBits.
- A sample occurs on a clk where sampleStrobe=1, dEnable=1 and the state is CAPTURE.
  - On a sample: shift register <= {shift[30:0], dIn}, and the bit counter increments.
  - The first bit of a word ends up in bit 31.
- Word completion: on the 32nd sample, the word is copied to the holding register on that same edge, with lastBits=32 and writeValid=1. Latency is 1 clk from the sampling edge to writeValid visible.
  - If the holding register is still occupied and is not transferring that cycle, the new word is dropped, overflow is set, and wordCount is unchanged.
  - Completion and transfer on the same cycle are legal: the new word replaces the old one, with no overflow.
- Transfer occurs when writeValid and writeReady are both 1.
  - wordCount increments by 1.
  - writeValid clears unless a new word loads on the same edge.
  - writeData holds its value until the next load.
- State machine:
  - IDLE: outputs held. On enable 0->1, latch captureNum, clear wordCount and overflow, and go to ARMED. If captureNum=0, go directly to DONE instead.
  - ARMED: wait for dEnable=1, then go to CAPTURE. Samples begin on the first qualifying strobe.
  - CAPTURE:
    - When wordCount reaches captureNum on a transfer, go to DONE; remaining stream bits are ignored.
    - When dEnable=0 with bit counter>0, go to FLUSH.
    - When dEnable=0 with bit counter=0, go to DRAIN.
  - FLUSH: when the holding register is free or transferring, load the partial word. It is shift<<(32-count), so left-aligned with low bits zero, and lastBits=count. Then go to DRAIN.
  - DRAIN: wait until writeValid=0, then go to DONE.
  - DONE: complete=1 and no further samples. A flushed partial word counts as a word toward wordCount and toward the captureNum limit.
- enable=0 in any state other than IDLE: go to IDLE next clk.
  - writeValid, complete and the bit counter clear.
  - wordCount and overflow hold until the next arm.
- wordCount saturates at 2^CNT_W-1 and does not wrap.
- sampleStrobe pulses may arrive on consecutive clks (one bit per clk); all logic sustains this rate.

Test Plan:
- captureNum=2, strobe every 4 clk, stream 0x6F3B2A1C then 0x12345678 MSB-first, writeReady=1 -> two transfers with those values, lastBits=32, wordCount=2, complete=1 two clk after the second transfer; any further bits are ignored.
- captureNum=4, 12 bits 0xABC, then dEnable=0 -> one transfer of 0xABC00000 with lastBits=12, wordCount=1, complete=1.
- captureNum=3, writeReady=0 for 80 sample strobes at strobe every clk -> first word held, second word dropped, overflow=1 sticky; raise writeReady -> 0xEABC9724 transferred.
- captureNum=0, enable rising edge -> complete=1 two clk later, no writeValid.
- Reset asserted for 1 clk after 20 bits of 0x33333333 -> all outputs 0 next clk; re-arm with stream 0x0F0F0F0F -> correct word, with no residue from the aborted capture.
- enable dropped mid-word at 17 bits -> IDLE, writeValid=0, complete=0; re-arm clears wordCount and overflow.
